// File: rtl/dm_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter_pkg
// Description : Shared definitions for the data-memory arbiter.
//               - Sequencer state encodings.
//               - The full-word byte-enable value.
//               - The default DM depth.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] BE_FULL          = 4'hF;
    localparam int         DM_WORDS_DEFAULT = 3072;

endpackage
`default_nettype wire

// File: rtl/dm_arbiter_byte_merge.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter_byte_merge
// Description : Combinational byte-lane merge. Each output byte comes from
//               new_word where the matching be bit is set, otherwise from
//               old_word.
// Ports       : old_word [31:0] in  - existing memory word
//               new_word [31:0] in  - lane-aligned store data
//               be       [3:0]  in  - byte enables (bit i -> bits 8i+7:8i)
//               merged   [31:0] out - combined word
// Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_lane
            assign merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter
// Description : Round-robin arbiter/sequencer between two requesters (m0 =
//               CPU MEM stage, m1 = loader/debug) and a single-port,
//               word-wide data memory with combinational read. Sub-word
//               stores are performed as an atomic read-modify-write.
//
// Ports       : clk, reset (async, active-high)
//               m{0,1}_req/we/be/addr/wd/pc   requester inputs
//               m{0,1}_ack/rd/err             requester responses (registered)
//               dm_we/dm_addr/dm_wd           DM command (registered)
//               dm_rd                         DM combinational read data
//
// Options     : DM_ARB_TRACE_EN - when defined, prints one trace line per DM
//               write cycle: "@<pc>: *<addr> <= <data>".
// Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DM_WORDS = DM_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [3:0]        m0_be,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wd,
    input  logic [31:0]       m0_pc,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [3:0]        m1_be,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wd,
    input  logic [31:0]       m1_pc,
    output logic              m0_ack,
    output logic [31:0]       m0_rd,
    output logic              m0_err,
    output logic              m1_ack,
    output logic [31:0]       m1_rd,
    output logic              m1_err,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wd,
    input  logic [31:0]       dm_rd
);

    localparam logic [31:0] DM_LIMIT = DM_WORDS[31:0];

    state_t            r_state;
    logic              r_rr_last;   // last granted master (0 = m0, 1 = m1)
    logic              r_we;
    logic [3:0]        r_be;
    logic [31:0]       r_wd;
    logic              r_oor;       // latched out-of-range flag

    // Winner selection: m1 wins when alone, or on a tie when m0 was last.
    logic              w_pick1;
    logic              w_sel_we;
    logic [3:0]        w_sel_be;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wd;
    logic              w_sel_oor;

    assign w_pick1    = m1_req && (!m0_req || !r_rr_last);
    assign w_sel_we   = w_pick1 ? m1_we   : m0_we;
    assign w_sel_be   = w_pick1 ? m1_be   : m0_be;
    assign w_sel_addr = w_pick1 ? m1_addr : m0_addr;
    assign w_sel_wd   = w_pick1 ? m1_wd   : m0_wd;
    assign w_sel_oor  = ({{(34-ADDR_W){1'b0}}, w_sel_addr[ADDR_W-1:2]} >= DM_LIMIT);

    // Only in-range stores with a partial, non-empty mask need the merge pass.
    logic        w_go_merge;
    logic        w_fire;
    logic        w_rd_upd;
    logic [31:0] w_rd_val;
    logic [31:0] w_merged;

    assign w_go_merge = r_we && !r_oor && (r_be != BE_FULL) && (r_be != 4'h0);
    assign w_fire     = ((r_state == ST_ACCESS) && !w_go_merge) || (r_state == ST_MERGE);
    assign w_rd_upd   = (r_state == ST_ACCESS) && (r_oor || !r_we);
    assign w_rd_val   = r_oor ? 32'h0 : dm_rd;

    dm_arbiter_byte_merge u_merge (
        .old_word (dm_rd),
        .new_word (r_wd),
        .be       (r_be),
        .merged   (w_merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rr_last <= 1'b1;
            r_we      <= 1'b0;
            r_be      <= 4'h0;
            r_wd      <= 32'h0;
            r_oor     <= 1'b0;
            m0_ack    <= 1'b0;
            m0_rd     <= 32'h0;
            m0_err    <= 1'b0;
            m1_ack    <= 1'b0;
            m1_rd     <= 32'h0;
            m1_err    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wd     <= 32'h0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        r_rr_last <= w_pick1;
                        r_we      <= w_sel_we;
                        r_be      <= w_sel_be;
                        r_wd      <= w_sel_wd;
                        r_oor     <= w_sel_oor;
                        // DM command is set up here so it is valid throughout ACCESS.
                        dm_addr   <= {w_sel_addr[ADDR_W-1:2], 2'b00};
                        dm_wd     <= w_sel_wd;
                        dm_we     <= w_sel_we && (w_sel_be == BE_FULL) && !w_sel_oor;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (w_go_merge) begin
                        dm_we   <= 1'b1;
                        dm_wd   <= w_merged;
                        r_state <= ST_MERGE;
                    end else begin
                        dm_we   <= 1'b0;
                        r_state <= ST_RESP;
                    end
                end
                ST_MERGE: begin
                    dm_we   <= 1'b0;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Response registers for the granted master; the other holds.
            if (w_fire) begin
                if (r_rr_last) begin
                    m1_ack <= 1'b1;
                    m1_err <= r_oor;
                    if (w_rd_upd) m1_rd <= w_rd_val;
                end else begin
                    m0_ack <= 1'b1;
                    m0_err <= r_oor;
                    if (w_rd_upd) m0_rd <= w_rd_val;
                end
            end
        end
    end

    // Word-offset address bits are never used by a word-wide memory.
    logic w_unused_addr;
    assign w_unused_addr = ^{m0_addr[1:0], m1_addr[1:0]};

`ifdef DM_ARB_TRACE_EN
    logic [31:0] r_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= 32'h0;
        end else if ((r_state == ST_IDLE) && (m0_req || m1_req)) begin
            r_pc <= w_pick1 ? m1_pc : m0_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (dm_we) begin
            $display("@%h: *%h <= %h", r_pc, {{(32-ADDR_W){1'b0}}, dm_addr}, dm_wd);
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^{m0_pc, m1_pc};
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_arbiter
// Description : Self-checking bench for dm_arbiter. A behavioural DM model
//               answers the DUT; a reference memory predicts load data and
//               store results, and expected responses are queued when a
//               request is issued and compared as each ack appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    localparam int ADDR_W = 16;
    localparam int WORDS  = 3072;

    logic              clk;
    logic              rst;
    logic              m0_req, m1_req;
    logic              m0_we, m1_we;
    logic [3:0]        m0_be, m1_be;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [31:0]       m0_wd, m1_wd, m0_pc, m1_pc;
    logic              m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0]       m0_rd, m1_rd;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wd, dm_rd;

    dm_arbiter #(.ADDR_W(ADDR_W), .DM_WORDS(WORDS)) u_dut (
        .clk     (clk),
        .reset   (rst),
        .m0_req  (m0_req),  .m0_we (m0_we), .m0_be (m0_be), .m0_addr (m0_addr),
        .m0_wd   (m0_wd),   .m0_pc (m0_pc),
        .m1_req  (m1_req),  .m1_we (m1_we), .m1_be (m1_be), .m1_addr (m1_addr),
        .m1_wd   (m1_wd),   .m1_pc (m1_pc),
        .m0_ack  (m0_ack),  .m0_rd (m0_rd), .m0_err (m0_err),
        .m1_ack  (m1_ack),  .m1_rd (m1_rd), .m1_err (m1_err),
        .dm_we   (dm_we),   .dm_addr (dm_addr), .dm_wd (dm_wd),
        .dm_rd   (dm_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DM model (written by the DUT) and reference memory (written by the bench).
    logic [31:0] mem     [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];
    int          dm_idx;
    int          we_cnt;

    assign dm_idx = int'(dm_addr[ADDR_W-1:2]);
    assign dm_rd  = (dm_idx < WORDS) ? mem[dm_idx] : 32'h0;

    initial we_cnt = 0;
    always @(posedge clk) begin
        if (dm_we) begin
            we_cnt = we_cnt + 1;
            if (dm_idx < WORDS) mem[dm_idx] = dm_wd;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          m;
        logic [31:0] rd;
        logic        err;
        logic        is_load;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] merge_bytes(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    // Predict the response of one transaction and update the reference memory.
    task automatic expect_txn(input int m, input logic we, input logic [3:0] be,
                              input logic [15:0] addr, input logic [31:0] wd);
        exp_t e;
        int   w;
        w         = int'(addr[15:2]);
        e.m       = m;
        e.err     = (w >= WORDS);
        e.is_load = !we;
        e.rd      = (w >= WORDS || we) ? 32'h0 : ref_mem[w];
        if (we && w < WORDS) ref_mem[w] = merge_bytes(ref_mem[w], wd, be);
        sb.push_back(e);
    endtask

    // Response monitor: every ack pops the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (m0_ack || m1_ack)) begin
            check_eq("ack_overlap", {31'h0, m0_ack & m1_ack}, 32'h0);
            if (sb.size() == 0) begin
                check_eq("unexpected_ack", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("ack_master", {31'h0, m1_ack}, (e.m == 1) ? 32'h1 : 32'h0);
                check_eq("err", {31'h0, (m1_ack ? m1_err : m0_err)}, {31'h0, e.err});
                if (e.is_load) check_eq("rd", m1_ack ? m1_rd : m0_rd, e.rd);
            end
        end
    end

    // Drive one request (called at a negedge); wait for its ack. lat=0 skips the
    // latency check; hold keeps req high for a follow-on request.
    task automatic do_req(input int m, input logic we, input logic [3:0] be,
                          input logic [15:0] addr, input logic [31:0] wd,
                          input int lat, input bit hold);
        int  n;
        logic got;
        if (m == 0) begin
            m0_we = we; m0_be = be; m0_addr = addr; m0_wd = wd; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_be = be; m1_addr = addr; m1_wd = wd; m1_req = 1'b1;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = (m == 0) ? m0_ack : m1_ack;
        end
        check_eq("ack_seen", {31'h0, got}, 32'h1);
        if (lat != 0) check_eq("latency", n, lat);
        if (!hold) begin
            if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
            @(negedge clk);
        end
    endtask

    // Single-master transaction with write-count and memory checks.
    task automatic solo(input int m, input logic we, input logic [3:0] be,
                        input logic [15:0] addr, input logic [31:0] wd);
        int w, lat, wes0, exp_wes;
        bit oor;
        w       = int'(addr[15:2]);
        oor     = (w >= WORDS);
        lat     = (we && !oor && be != 4'hF && be != 4'h0) ? 3 : 2;
        exp_wes = (we && !oor && be != 4'h0) ? 1 : 0;
        wes0    = we_cnt;
        expect_txn(m, we, be, addr, wd);
        do_req(m, we, be, addr, wd, lat, 1'b0);
        check_eq("dm_we_count", we_cnt - wes0, exp_wes);
        if (!oor) check_eq("mem_word", mem[w], ref_mem[w]);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = (i * 32'h01010101) ^ 32'hA5A5_5A5A;
            ref_mem[i] = (i * 32'h01010101) ^ 32'hA5A5_5A5A;
        end
        m0_req = 0; m0_we = 0; m0_be = 0; m0_addr = 0; m0_wd = 0; m0_pc = 32'h0000_3008;
        m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wd = 0; m1_pc = 32'h0000_4000;
        rst = 1'b1;
        #1;
        check_eq("rst_m0_ack", {31'h0, m0_ack}, 32'h0);
        check_eq("rst_m1_ack", {31'h0, m1_ack}, 32'h0);
        check_eq("rst_m0_err", {31'h0, m0_err}, 32'h0);
        check_eq("rst_m1_err", {31'h0, m1_err}, 32'h0);
        check_eq("rst_m0_rd", m0_rd, 32'h0);
        check_eq("rst_m1_rd", m1_rd, 32'h0);
        check_eq("rst_dm_we", {31'h0, dm_we}, 32'h0);
        check_eq("rst_dm_addr", {16'h0, dm_addr}, 32'h0);
        check_eq("rst_dm_wd", dm_wd, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Both request on the same edge after reset: expect m0,m1,m0,m1.
        expect_txn(0, 1'b0, 4'h0, 16'h0100, 32'h0);
        expect_txn(1, 1'b0, 4'h0, 16'h0200, 32'h0);
        expect_txn(0, 1'b0, 4'h0, 16'h0104, 32'h0);
        expect_txn(1, 1'b0, 4'h0, 16'h0204, 32'h0);
        fork
            begin
                do_req(0, 1'b0, 4'h0, 16'h0100, 32'h0, 0, 1'b1);
                do_req(0, 1'b0, 4'h0, 16'h0104, 32'h0, 0, 1'b0);
            end
            begin
                do_req(1, 1'b0, 4'h0, 16'h0200, 32'h0, 0, 1'b1);
                do_req(1, 1'b0, 4'h0, 16'h0204, 32'h0, 0, 1'b0);
            end
        join

        // Full-word store then load.
        solo(0, 1'b1, 4'hF, 16'h0010, 32'hDEADBEEF);
        solo(0, 1'b0, 4'h0, 16'h0010, 32'h0);
        check_eq("m0_rd_deadbeef", m0_rd, 32'hDEADBEEF);

        // Partial store via read-modify-write, then reload.
        mem[8]     = 32'h11223344;
        ref_mem[8] = 32'h11223344;
        solo(1, 1'b1, 4'b0010, 16'h0020, 32'h0000AA00);
        solo(1, 1'b0, 4'h0, 16'h0020, 32'h0);
        check_eq("m1_rd_merged", m1_rd, 32'h1122AA44);

        // Empty mask, boundary word, out-of-range load and store.
        solo(0, 1'b1, 4'h0, 16'h0030, 32'hFFFFFFFF);
        solo(0, 1'b0, 4'h0, 16'h2FFC, 32'h0);
        solo(0, 1'b0, 4'h0, 16'h3000, 32'h0);
        check_eq("oor_rd_zero", m0_rd, 32'h0);
        solo(1, 1'b1, 4'hF, 16'hFFFC, 32'h12345678);

        // Mixed random traffic.
        for (int k = 0; k < 12; k++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 16'h3100)) & 16'hFFFC;
            solo(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), a, $urandom);
        end

        // Reset while m1's partial store is in MERGE: no write, no ack.
        m1_we = 1'b1; m1_be = 4'b0100; m1_addr = 16'h0040; m1_wd = 32'h00770000;
        m1_req = 1'b1;
        @(negedge clk);
        check_eq("access_no_we", {31'h0, dm_we}, 32'h0);
        @(negedge clk);
        check_eq("merge_we", {31'h0, dm_we}, 32'h1);
        rst = 1'b1;
        #1;
        check_eq("rst_merge_we", {31'h0, dm_we}, 32'h0);
        check_eq("rst_merge_ack", {31'h0, m1_ack}, 32'h0);
        m1_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mem_kept", mem[16], ref_mem[16]);

        // Tie after reset goes to m0.
        expect_txn(0, 1'b0, 4'h0, 16'h0040, 32'h0);
        expect_txn(1, 1'b0, 4'h0, 16'h0044, 32'h0);
        fork
            do_req(0, 1'b0, 4'h0, 16'h0040, 32'h0, 2, 1'b0);
            do_req(1, 1'b0, 4'h0, 16'h0044, 32'h0, 0, 1'b0);
        join

        repeat (3) @(negedge clk);
        check_eq("sb_drained", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
